count_stream_checker: RTL and testbench
=======================================

# count_stream_checker

Monitors the 4-bit count stream produced by the prescaled up-counter and confirms it advances by exactly +1 modulo 16. It flags skipped values and stalls, and counts errors. The block sits at the consuming end of the counter output bus. It is used on-chip to confirm that an obfuscated counter netlist still behaves like the clear one after bitstream transformation.

## Interface
Parameters:
- `CNT_W`, 4: width of the observed count.
- `STALL_CYCLES`, 64: number of `clk` cycles without a step, while `mon_en`=1, that raises a stall error. Legal range is 2..2^20.
- `LOCK_STEPS`, 3: number of consecutive legal steps needed to reach LOCKED.

Ports:
- `clk`, in, 1: the only clock. It is the same clock that drives the counter's prescaler.
- `reset`, in, 1: asynchronous, active-low reset. Asserted when 0, released synchronously to `clk`.
- `mon_en`, in, 1: monitoring enable. Mirrors the counter's `enable`.
- `dut_rst`, in, 1: the counter's own reset (active-high). While it is 1, a change to 0 is legal.
- `clear`, in, 1: synchronous clear of the error counter and the FSM.
- `cnt_in`, in, `CNT_W`: the observed count bus.
- `step`, out, 1: one-cycle pulse on each legal +1 step.
- `err_skip`, out, 1: one-cycle pulse on an illegal value change.
- `err_stall`, out, 1: one-cycle pulse when the stall timer expires.
- `locked`, out, 1: level, high while the FSM is in LOCKED.
- `err_count`, out, 8: error counter that saturates at 255.
- `last_val`, out, `CNT_W`: the most recently accepted count value.

## Operation
- `cnt_in` is registered into `cur`. The previous value of `cur` is held in `prev`.
- A change is `cur != prev`.
- A legal change is `cur == prev+1` modulo 2^`CNT_W` (so 15→0 is legal), or `cur == 0` with `dut_rst`=1.
- FSM states are IDLE, ACQUIRE, LOCKED and FAULT:
  - IDLE: entered on reset, on `clear`, or while `mon_en`=0. Goes to ACQUIRE when `mon_en`=1.
  - ACQUIRE: a legal change increments `good_cnt`. When `good_cnt` reaches `LOCK_STEPS`, go to LOCKED. An illegal change or a stall resets `good_cnt` to 0 and stays in ACQUIRE. No errors are counted in this state.
  - LOCKED: a legal change pulses `step`. An illegal change pulses `err_skip` and goes to FAULT. A stall pulses `err_stall` and goes to FAULT. Each error increments `err_count`.
  - FAULT: `locked`=0. On the next change, go to ACQUIRE with `good_cnt`=0. Stall timers in FAULT raise no pulses.
- `step` also pulses on legal changes in ACQUIRE. `err_*` pulse only in LOCKED.
- Stall timer:
  - Resets to 0 on any change, or when `mon_en`=0.
  - Otherwise increments by 1 per cycle.
  - Expires when it reaches `STALL_CYCLES`-1, then restarts from 0.
- `last_val` loads `cur` on every change, whether legal or illegal.
- `err_count` saturates at 255 with no wrap.
- Priority, highest first: `reset`, then `clear`, then `mon_en`=0, then the change/stall evaluation.
- A change and a stall expiry in the same cycle resolve as a change, because a change resets the timer.

## Timing
- Reset values: `step`=`err_skip`=`err_stall`=`locked`=0, `err_count`=0, `last_val`=0, `cur`=`prev`=0, FSM=IDLE.
- Latency is 2 cycles from `cnt_in` changing to the corresponding pulse: edge N captures `cur`, edge N+1 registers the outputs.
- All outputs are registered. There are no combinational paths from input to output.
- `locked` rises in the same cycle as the `LOCK_STEPS`-th `step` pulse.
- `err_count` reflects an error on the cycle after the error pulse.
- `clear` takes effect on the next edge. In the cycle after `clear`: `err_count`=0, FSM=IDLE, all pulses low.
- `reset` asserted mid-operation clears every output immediately. It does not need a clock.
- Pulses never last more than 1 cycle. At most one of `step`, `err_skip` and `err_stall` is high in any cycle.

## Structure
- The shared package `cnt_check_pkg` holds:
  - the `chk_state_t` enum: IDLE, ACQUIRE, LOCKED, FAULT;
  - the `ERR_CNT_W`=8 constant;
  - a `stall_w(STALL_CYCLES)` function that computes the timer width.
- Sub-module `stall_timer`:
  - Inputs: `clk`, `reset`, `restart`, `run`.
  - Output: a one-cycle `expired` pulse.
  - Parameter: `STALL_CYCLES`.
  - It holds the timer, so the top level contains only registers, the FSM and the comparators.

## Test plan
- Reset, `mon_en`=1, drive `cnt_in` 0,1,2,3 with 4 cycles per value. Expect:
  - `step` pulses each 2 cycles after its change;
  - `locked`=1 with the third step;
  - `err_count`=0.
- When locked, drive 5→7. Expect:
  - `err_skip` for one cycle;
  - `err_count`=1;
  - FSM=FAULT and `locked`=0;
  - the next change returns to ACQUIRE;
  - `last_val`=7.
- When locked, drive 14,15,0,1. Expect:
  - wrap 15→0 is legal;
  - three `step` pulses and no error pulse.
- When locked, hold `cnt_in`=9 with `STALL_CYCLES`=8. Expect:
  - `err_stall` exactly 8 cycles after the last capture;
  - `err_count` increments by 1;
  - no second pulse while in FAULT.
- When locked, drive 6→0 with `dut_rst`=1. Expect a legal change with no error.
- Force 300 errors through repeated relock/skip cycles. Expect:
  - `err_count` holds at 255;
  - `clear` sets it to 0 on the next cycle;
  - `reset`=0 mid-sequence clears all outputs asynchronously.

Source files
------------

// File: rtl/cnt_check_pkg.sv
// -----------------------------------------------------------------------------
// cnt_check_pkg
// Shared types and constants for the count stream checker.
//   chk_state_t : checker FSM states (IDLE, ACQUIRE, LOCKED, FAULT)
//   ERR_CNT_W   : width of the saturating error counter
//   stall_w()   : width of a timer that must hold 0 .. stall_cycles-1
// -----------------------------------------------------------------------------
package cnt_check_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } chk_state_t;

    localparam int ERR_CNT_W = 8;

    // The timer counts 0 .. stall_cycles-1, so it needs clog2(stall_cycles)
    // bits, with a floor of one bit for the smallest legal setting.
    function automatic int stall_w(input int stall_cycles);
        int w;
        w = $clog2(stall_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// -----------------------------------------------------------------------------
// stall_timer
// Counts cycles without a count change and flags expiry.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   restart : force the timer back to 0 (a change was seen or monitoring is off)
//   run     : advance the timer by one per cycle when not restarting
//   expired : one-cycle pulse while the timer sits at STALL_CYCLES-1 and is
//             about to advance; the timer then restarts from 0
// -----------------------------------------------------------------------------
module stall_timer
    import cnt_check_pkg::*;
#(
    parameter int STALL_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam int            TW   = stall_w(STALL_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(STALL_CYCLES - 1);

    logic [TW-1:0] tmr;

    // A restart wins over expiry: a change in the expiry cycle is a change.
    assign expired = run && !restart && (tmr == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (restart) begin
            tmr <= '0;
        end else if (run) begin
            tmr <= expired ? '0 : tmr + 1'b1;
        end
    end

endmodule

// File: rtl/count_stream_checker.sv
// -----------------------------------------------------------------------------
// count_stream_checker
// Watches the count bus of the prescaled up-counter and confirms it advances
// by exactly +1 modulo 2^CNT_W. Flags skipped values and stalls and keeps a
// saturating error count.
//   clk       : the only clock (shared with the counter's prescaler)
//   reset     : asynchronous active-low reset, released synchronously
//   mon_en    : monitoring enable (mirrors the counter's enable)
//   dut_rst   : counter's own active-high reset; a change to 0 is legal then
//   clear     : synchronous clear of the error counter and the FSM
//   cnt_in    : observed count bus
//   step      : pulse on each legal +1 step (ACQUIRE or LOCKED)
//   err_skip  : pulse on an illegal value change while LOCKED
//   err_stall : pulse when the stall timer expires while LOCKED
//   locked    : high while the FSM is in LOCKED
//   err_count : saturating error counter
//   last_val  : most recently accepted (changed-to) count value
// All outputs are registered; a cnt_in change shows up on the outputs two
// edges later (edge N captures cur, edge N+1 registers the verdict).
// -----------------------------------------------------------------------------
module count_stream_checker
    import cnt_check_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int STALL_CYCLES = 64,
    parameter int LOCK_STEPS   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mon_en,
    input  logic                 dut_rst,
    input  logic                 clear,
    input  logic [CNT_W-1:0]     cnt_in,
    output logic                 step,
    output logic                 err_skip,
    output logic                 err_stall,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [CNT_W-1:0]     last_val
);

    // good_cnt only ever holds 0 .. LOCK_STEPS-1; the final legal step locks.
    localparam int            GW        = (LOCK_STEPS > 1) ? $clog2(LOCK_STEPS) : 1;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_STEPS - 1);

    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] prev;
    logic [CNT_W-1:0] prev_inc;
    logic             change;
    logic             legal;
    logic             stall_exp;

    chk_state_t       state_q;
    chk_state_t       state_d;
    logic [GW-1:0]    good_q;
    logic [GW-1:0]    good_d;
    logic             step_d;
    logic             skip_d;
    logic             stall_d;
    logic             err_inc;

    // ---------------------------------------------------------------- capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur  <= '0;
            prev <= '0;
        end else begin
            cur  <= cnt_in;
            prev <= cur;
        end
    end

    // ------------------------------------------------------------ comparators
    // prev_inc is CNT_W wide, so 2^CNT_W-1 -> 0 wraps naturally.
    assign prev_inc = prev + 1'b1;
    assign change   = (cur != prev);
    assign legal    = change && ((cur == prev_inc) || ((cur == '0) && dut_rst));

    // ------------------------------------------------------------ stall timer
    stall_timer #(
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (change || !mon_en),
        .run     (mon_en),
        .expired (stall_exp)
    );

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        step_d  = 1'b0;
        skip_d  = 1'b0;
        stall_d = 1'b0;
        err_inc = 1'b0;

        if (clear || !mon_en) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end

                ACQUIRE: begin
                    if (legal) begin
                        step_d = 1'b1;
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else if (change || stall_exp) begin
                        // Errors here only restart the lock attempt.
                        good_d = '0;
                    end
                end

                LOCKED: begin
                    if (legal) begin
                        step_d = 1'b1;
                    end else if (change) begin
                        skip_d  = 1'b1;
                        err_inc = 1'b1;
                        state_d = FAULT;
                    end else if (stall_exp) begin
                        stall_d = 1'b1;
                        err_inc = 1'b1;
                        state_d = FAULT;
                    end
                end

                FAULT: begin
                    // Any movement re-arms acquisition; stalls stay silent.
                    if (change) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------ registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step      <= 1'b0;
            err_skip  <= 1'b0;
            err_stall <= 1'b0;
            locked    <= 1'b0;
        end else begin
            step      <= step_d;
            err_skip  <= skip_d;
            err_stall <= stall_d;
            locked    <= (state_d == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

    // last_val follows every monitored change, legal or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_val <= '0;
        end else if (!clear && mon_en && change) begin
            last_val <= cur;
        end
    end

endmodule

// File: tb/tb_count_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_count_stream_checker
// Directed scenarios plus randomized stimulus, every cycle compared against a
// behavioural model of the checking rules.
// -----------------------------------------------------------------------------
module tb_count_stream_checker;

    localparam int CNT_W = 4;
    localparam int STALL = 8;
    localparam int LOCK  = 3;
    localparam int MODV  = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       mon_en  = 1'b0;
    logic       dut_rst = 1'b0;
    logic       clear   = 1'b0;
    logic [3:0] cnt_in  = 4'd0;

    logic       step;
    logic       err_skip;
    logic       err_stall;
    logic       locked;
    logic [7:0] err_count;
    logic [3:0] last_val;

    count_stream_checker #(
        .CNT_W        (CNT_W),
        .STALL_CYCLES (STALL),
        .LOCK_STEPS   (LOCK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mon_en    (mon_en),
        .dut_rst   (dut_rst),
        .clear     (clear),
        .cnt_in    (cnt_in),
        .step      (step),
        .err_skip  (err_skip),
        .err_stall (err_stall),
        .locked    (locked),
        .err_count (err_count),
        .last_val  (last_val)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_step, obs_skip, obs_stall;

    // ------------------------------------------------------------------ model
    typedef enum {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mode_t;
    mode_t m_mode;
    int    m_good, m_quiet, m_err, m_last, m_cur, m_prev;
    bit    e_step, e_skip, e_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_good  = 0;
        m_quiet = 0;
        m_err   = 0;
        m_last  = 0;
        m_cur   = 0;
        m_prev  = 0;
        e_step  = 0;
        e_skip  = 0;
        e_stall = 0;
    endtask

    // One clock edge: judge the pair captured before the edge, then capture.
    task automatic model_edge();
        bit chg, legal, expire, err;
        chg    = (m_cur != m_prev);
        legal  = chg && ((m_cur == (m_prev + 1) % MODV) || (m_cur == 0 && dut_rst));
        expire = mon_en && !chg && (m_quiet == STALL - 1);
        e_step  = 0;
        e_skip  = 0;
        e_stall = 0;
        err     = 0;
        if (clear || !mon_en) begin
            m_mode = M_IDLE;
            m_good = 0;
        end else begin
            case (m_mode)
                M_IDLE:  begin m_mode = M_ACQ; m_good = 0; end
                M_ACQ: begin
                    if (legal) begin
                        e_step = 1;
                        m_good++;
                        if (m_good == LOCK) begin m_mode = M_LOCK; m_good = 0; end
                    end else if (chg || expire) begin
                        m_good = 0;
                    end
                end
                M_LOCK: begin
                    if (legal)       e_step = 1;
                    else if (chg)    begin e_skip  = 1; err = 1; m_mode = M_FAULT; end
                    else if (expire) begin e_stall = 1; err = 1; m_mode = M_FAULT; end
                end
                M_FAULT: if (chg) begin m_mode = M_ACQ; m_good = 0; end
            endcase
        end
        if (clear) m_err = 0;
        else if (err && m_err < 255) m_err++;
        if (mon_en && !clear && chg) m_last = m_cur;
        m_quiet = (chg || !mon_en || expire) ? 0 : m_quiet + 1;
        m_prev  = m_cur;
        m_cur   = int'(cnt_in);
    endtask

    task automatic compare_all();
        check("step",      step,      e_step);
        check("err_skip",  err_skip,  e_skip);
        check("err_stall", err_stall, e_stall);
        check("locked",    locked,    (m_mode == M_LOCK));
        check("err_count", err_count, m_err);
        check("last_val",  last_val,  m_last);
        check("one_pulse", (32'(step) + 32'(err_skip) + 32'(err_stall)) <= 1, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        @(negedge clk);
        compare_all();
        obs_step  += int'(step);
        obs_skip  += int'(err_skip);
        obs_stall += int'(err_stall);
    endtask

    task automatic drive(input int v, input int hold);
        cnt_in = 4'(v % MODV);
        repeat (hold) tick();
    endtask

    task automatic clr_obs();
        obs_step  = 0;
        obs_skip  = 0;
        obs_stall = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v, k;
        bit seen;
        clr_obs();
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_err_count", err_count, 0);
        check("rst_locked",    locked,    0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Acquire lock on 0,1,2,3
        drive(0, 4);
        clr_obs();
        drive(1, 4); drive(2, 4); drive(3, 4);
        check("acq_steps",     obs_step, 3);
        check("acq_locked",    locked,   1);
        check("acq_err_count", err_count, 0);

        // Skip 5 -> 7
        drive(4, 4); drive(5, 4);
        clr_obs();
        drive(7, 4);
        check("skip_pulses",    obs_skip,  1);
        check("skip_err_count", err_count, 1);
        check("skip_locked",    locked,    0);
        check("skip_last_val",  last_val,  7);
        drive(8, 4); drive(9, 4); drive(10, 4); drive(11, 4);
        check("relock", locked, 1);

        // Wrap 14,15,0,1
        drive(12, 4); drive(13, 4); drive(14, 4);
        clr_obs();
        drive(15, 4); drive(0, 4); drive(1, 4);
        check("wrap_steps",  obs_step, 3);
        check("wrap_errors", obs_skip + obs_stall, 0);
        check("wrap_locked", locked, 1);

        // Stall while holding 9
        for (int i = 2; i <= 8; i++) drive(i, 2);
        clr_obs();
        cnt_in = 4'd9;
        tick();
        tick();
        check("stall_pre_step", step, 1);
        k = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            k++;
            seen = err_stall;
        end
        check("stall_delay", k, STALL);
        repeat (24) tick();
        check("stall_pulses",    obs_stall, 1);
        check("stall_err_count", err_count, 2);
        check("stall_locked",    locked,    0);

        // 6 -> 0 under dut_rst
        for (int i = 10; i <= 22; i++) drive(i, 2);
        check("rst_path_locked", locked, 1);
        clr_obs();
        dut_rst = 1'b1;
        drive(0, 4);
        dut_rst = 1'b0;
        check("dutrst_step",      obs_step,  1);
        check("dutrst_no_err",    obs_skip + obs_stall, 0);
        check("dutrst_err_count", err_count, 2);
        check("dutrst_last_val",  last_val,  0);

        // Randomized stream
        v = 0;
        for (int it = 0; it < 700; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      v = (v + 1) % MODV;
            else if (r < 85) v = int'($urandom_range(0, MODV - 1));
            mon_en  = ($urandom_range(0, 29) != 0);
            dut_rst = ($urandom_range(0, 9) == 0);
            clear   = ($urandom_range(0, 99) == 0);
            if (clear) begin
                cnt_in = 4'(v);
                tick();
                clear = 1'b0;
            end
            drive(v, ($urandom_range(0, 19) == 0) ? 12 : int'($urandom_range(1, 3)));
        end
        mon_en  = 1'b1;
        dut_rst = 1'b0;
        clear   = 1'b0;

        // Saturation: 320 lock/skip rounds
        clr_obs();
        for (int it = 0; it < 320; it++) begin
            for (int j = 0; j < 5; j++) begin
                v = (v + 1) % MODV;
                drive(v, 2);
            end
            v = (v + 2) % MODV;
            drive(v, 2);
        end
        check("sat_skips",     obs_skip,  320);
        check("sat_err_count", err_count, 255);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_err_count", err_count, 0);
        check("clear_locked",    locked,    0);
        check("clear_pulses",    32'(step) + 32'(err_skip) + 32'(err_stall), 0);

        // Asynchronous reset mid-operation
        for (int j = 0; j < 6; j++) begin
            v = (v + 1) % MODV;
            drive(v, 2);
        end
        v = (v + 3) % MODV;
        drive(v, 2);
        for (int j = 0; j < 6; j++) begin
            v = (v + 1) % MODV;
            drive(v, 2);
        end
        check("pre_rst_locked",    locked,    1);
        check("pre_rst_err_count", err_count, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_step",      step,      0);
        check("arst_err_skip",  err_skip,  0);
        check("arst_err_stall", err_stall, 0);
        check("arst_locked",    locked,    0);
        check("arst_err_count", err_count, 0);
        check("arst_last_val",  last_val,  0);
        repeat (2) tick();
        reset = 1'b1;
        for (int j = 0; j < 6; j++) begin
            v = (v + 1) % MODV;
            drive(v, 2);
        end
        check("post_rst_locked", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
